ysyx_24080014_pcgen: RTL and testbench

YSYX_24080014_PCGEN -- requirements
Module: ysyx_24080014_pcgen

---
 rtl/ysyx_24080014_pcgen_if.sv | 22 ++
 rtl/ysyx_24080014_pcgen.sv | 61 ++++++
 tb/tb_ysyx_24080014_pcgen.sv | 109 ++++++++++
 3 files changed

// File: rtl/ysyx_24080014_pcgen_if.sv
// ysyx_24080014_pcgen_if: fetch-PC handshake, redirect/trap requests and commit report
// master (pcgen): drives pc_valid, pc, commit_valid, commit_pc; samples pc_ready, redir_*, trap_*
// slave (fetch/control side): the mirror image
interface ysyx_24080014_pcgen_if #(parameter int XLEN = 32);
  logic pc_valid;
  logic pc_ready;
  logic [XLEN-1:0] pc;
  logic redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic commit_valid;
  logic [XLEN-1:0] commit_pc;
  modport master (
    output pc_valid, pc, commit_valid, commit_pc,
    input pc_ready, redir_valid, redir_pc, trap_valid, trap_vec
  );
  modport slave (
    input pc_valid, pc, commit_valid, commit_pc,
    output pc_ready, redir_valid, redir_pc, trap_valid, trap_vec
  );
endinterface

// File: rtl/ysyx_24080014_pcgen.sv
// ysyx_24080014_pcgen: fetch PC generator with BOOT/RUN/HALT control, trap/redirect and commit trace
// ports: clk, rst (sync, active-low), bus (ysyx_24080014_pcgen_if.master), halt_req,
//        epoch (flips per applied redirect/trap), perf_fire/perf_stall (64-bit counters)
// YSYX_24080014_PCGEN_PERF_EN: when defined, perf counters exist; otherwise they read constant 0
module ysyx_24080014_pcgen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter int STEP = 4
) (
  input  logic clk,
  input  logic rst,
  ysyx_24080014_pcgen_if.master bus,
  input  logic halt_req,
  output logic epoch,
  output logic [63:0] perf_fire,
  output logic [63:0] perf_stall
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam logic [XLEN-1:0] MASK = ~XLEN'(STEP - 1);
  state_t state, state_n;
  logic fire, redirect;
  logic [XLEN-1:0] pc_n;
  assign fire = bus.pc_valid & bus.pc_ready;
  assign redirect = bus.trap_valid | bus.redir_valid;
  always_ff @(posedge clk)
    state <= !rst ? BOOT : state_n;
  // BOOT (and any illegal encoding) always moves to RUN; RUN and HALT follow halt_req
  always_comb
    state_n = (state == RUN || state == HALT) && halt_req ? HALT : RUN;
  always_comb
    bus.pc_valid = state == RUN;
  always_comb
    pc_n = bus.trap_valid ? bus.trap_vec & MASK :
           bus.redir_valid ? bus.redir_pc & MASK :
           fire ? bus.pc + XLEN'(STEP) : bus.pc;
  always_ff @(posedge clk)
    if (!rst) begin
      bus.pc <= RESET_VEC;
      epoch <= 1'b0;
      bus.commit_valid <= 1'b0;
      bus.commit_pc <= '0;
    end else begin
      bus.pc <= pc_n;
      epoch <= epoch ^ redirect;
      bus.commit_valid <= fire;
      bus.commit_pc <= bus.pc;
    end
`ifdef YSYX_24080014_PCGEN_PERF_EN
  always_ff @(posedge clk)
    if (!rst) begin
      perf_fire <= '0;
      perf_stall <= '0;
    end else begin
      perf_fire <= perf_fire + 64'(fire);
      perf_stall <= perf_stall + 64'(bus.pc_valid & ~bus.pc_ready);
    end
`else
  assign perf_fire = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_ysyx_24080014_pcgen.sv
// tb_ysyx_24080014_pcgen: directed cycle-by-cycle vectors plus reset/launch sequences for pcgen
module tb_ysyx_24080014_pcgen;
  typedef struct {
    logic rst, rdy, halt, rv;
    logic [31:0] rpc;
    logic tv;
    logic [31:0] tvec;
    logic pv;
    logic [31:0] pc;
    logic ep, cv;
    logic [31:0] cpc;
    int f, s;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic halt_req;
  logic epoch;
  logic [63:0] perf_fire, perf_stall;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  ysyx_24080014_pcgen_if #(.XLEN(32)) bus ();
  ysyx_24080014_pcgen dut (
    .clk(clk), .rst(rst), .bus(bus), .halt_req(halt_req),
    .epoch(epoch), .perf_fire(perf_fire), .perf_stall(perf_stall)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic rd, logic h, logic rv, logic [31:0] rpc, logic tv,
                              logic [31:0] tvec, logic pv, logic [31:0] pc, logic ep, logic cv,
                              logic [31:0] cpc, int f, int s);
    vec_t v;
    v.rst = r; v.rdy = rd; v.halt = h; v.rv = rv; v.rpc = rpc; v.tv = tv; v.tvec = tvec;
    v.pv = pv; v.pc = pc; v.ep = ep; v.cv = cv; v.cpc = cpc; v.f = f; v.s = s;
    return v;
  endfunction
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(logic r, logic rd, logic h, logic rv, logic [31:0] rpc, logic tv, logic [31:0] tvec);
    rst = r; bus.pc_ready = rd; halt_req = h;
    bus.redir_valid = rv; bus.redir_pc = rpc; bus.trap_valid = tv; bus.trap_vec = tvec;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(string n, logic pv, logic [31:0] pc, logic ep, logic cv, logic [31:0] cpc, int f, int s);
    logic [63:0] fe, se;
`ifdef YSYX_24080014_PCGEN_PERF_EN
    fe = 64'(f); se = 64'(s);
`else
    fe = 0; se = 0;
`endif
    chk({n, "_pv"}, 64'(bus.pc_valid), 64'(pv));
    chk({n, "_pc"}, 64'(bus.pc), 64'(pc));
    chk({n, "_epoch"}, 64'(epoch), 64'(ep));
    chk({n, "_cv"}, 64'(bus.commit_valid), 64'(cv));
    chk({n, "_cpc"}, 64'(bus.commit_pc), 64'(cpc));
    chk({n, "_pfire"}, perf_fire, fe);
    chk({n, "_pstall"}, perf_stall, se);
  endtask
  initial begin
    //             rst rdy hlt rv rpc           tv tvec          pv pc            ep cv cpc          f  s
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h80000000, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000000, 0, 0, 32'h80000000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000000, 0, 0, 32'h80000000, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000000, 0, 0, 32'h80000000, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000000, 0, 0, 32'h80000000, 0, 3));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000004, 0, 1, 32'h80000000, 1, 3));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000008, 0, 1, 32'h80000004, 2, 3));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8000000C, 0, 1, 32'h80000008, 3, 3));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000010, 0, 1, 32'h8000000C, 4, 3));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h80000014, 0, 1, 32'h80000010, 5, 3));
    tbl.push_back(mk(1, 1, 1, 1, 32'h80000100, 0, 32'h0,        0, 32'h80000100, 1, 0, 32'h80000014, 5, 3));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80000100, 1, 0, 32'h80000100, 5, 3));
    tbl.push_back(mk(1, 0, 0, 1, 32'h80002000, 1, 32'h80001003, 1, 32'h80001000, 0, 0, 32'h80000100, 5, 4));
    tbl.push_back(mk(1, 1, 0, 1, 32'h80003002, 0, 32'h0,        1, 32'h80003000, 1, 1, 32'h80001000, 6, 4));
    tbl.push_back(mk(1, 0, 0, 1, 32'hFFFFFFFE, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0, 32'h80003000, 6, 5));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h00000000, 0, 1, 32'hFFFFFFFC, 7, 5));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h00000004, 0, 1, 32'h00000000, 8, 5));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h80000000, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h80000000, 0, 0, 32'h80000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h55555554, 1, 32'h00001234, 0, 32'h80000000, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h00000010, 1, 32'h00000010, 1, 0, 32'h80000000, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h00000014, 1, 1, 32'h00000010, 1, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].halt, tbl[i].rv, tbl[i].rpc, tbl[i].tv, tbl[i].tvec);
      chk_out($sformatf("row%0d", i), tbl[i].pv, tbl[i].pc, tbl[i].ep, tbl[i].cv, tbl[i].cpc, tbl[i].f, tbl[i].s);
    end
    // launch from reset with pc_ready held high: commit_pc trails pc by one cycle
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("boot0", 0, 32'h80000000, 0, 0, 32'h0, 0, 0);
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("boot1", 1, 32'h80000000, 0, 0, 32'h80000000, 0, 0);
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("boot2", 1, 32'h80000004, 0, 1, 32'h80000000, 1, 0);
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("boot3", 1, 32'h80000008, 0, 1, 32'h80000004, 2, 0);
    // reset while a fire is pending drops the in-flight commit and returns to BOOT
    drive(0, 1, 1, 1, 32'h80000200, 0, 32'h0);
    chk_out("rstfire", 0, 32'h80000000, 0, 0, 32'h0, 0, 0);
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("rstboot", 1, 32'h80000000, 0, 0, 32'h80000000, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
